// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract operand sequencer and its adder-side neighbours.
// Holds the FSM state encoding and the add/sub select codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HAVE_X = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag.
// Used to hold a timed stage for a fixed number of cycles.
module settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/addsub_operand_sequencer.sv
// Operand capture, adder settle wait and result hold for the W-bit add/sub ripple adder.
// Two operands arrive on a shared bus; the registered result is held until acknowledged.
module addsub_operand_sequencer
    import addsub_pkg::*;
#(
    parameter int W             = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         load,
    input  logic         sel_in,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         sel_out,
    input  logic [W-1:0] sum_in,
    input  logic         ovf_in,
    input  logic         cout_in,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         result_ovf,
    output logic         result_cout,
    output logic         result_valid,
    input  logic         result_ack
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_e       state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         sel_q, sel_d;
    logic [W-1:0] res_q, res_d;
    logic         res_ovf_q, res_ovf_d;
    logic         res_cout_q, res_cout_d;
    logic         valid_q, valid_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

    settle_timer #(
        .WIDTH (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_INIT),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        sel_d      = sel_q;
        res_d      = res_q;
        res_ovf_d  = res_ovf_q;
        res_cout_d = res_cout_q;
        valid_d    = valid_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    x_d     = din;
                    state_d = S_HAVE_X;
                end
            end
            S_HAVE_X: begin
                if (load) begin
                    y_d      = din;
                    sel_d    = (sel_in == OP_SUB) ? OP_SUB : OP_ADD;
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Adder inputs have been stable for SETTLE_CYCLES edges once the timer hits zero.
                if (tmr_zero) begin
                    res_d      = sum_in;
                    res_ovf_d  = ovf_in;
                    res_cout_d = cout_in;
                    valid_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            sel_q      <= 1'b0;
            res_q      <= '0;
            res_ovf_q  <= 1'b0;
            res_cout_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sel_q      <= sel_d;
            res_q      <= res_d;
            res_ovf_q  <= res_ovf_d;
            res_cout_q <= res_cout_d;
            valid_q    <= valid_d;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign sel_out      = sel_q;
    assign busy         = (state_q == S_SETTLE) || (state_q == S_DONE);
    assign result       = res_q;
    assign result_ovf   = res_ovf_q;
    assign result_cout  = res_cout_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Directed bench for addsub_operand_sequencer with a behavioural W-bit add/sub adder.
// Table-driven transactions plus hand-written hold, reset and back-to-back sequences.
module tb_addsub_operand_sequencer;

    localparam int W             = 6;
    localparam int SETTLE_CYCLES = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         load;
    logic         sel_in;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic         sel_out;
    logic [W-1:0] sum_in;
    logic         ovf_in;
    logic         cout_in;
    logic         busy;
    logic [W-1:0] result;
    logic         result_ovf;
    logic         result_cout;
    logic         result_valid;
    logic         result_ack;

    int checks = 0;
    int errors = 0;

    addsub_operand_sequencer #(
        .W             (W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .load         (load),
        .sel_in       (sel_in),
        .x_out        (x_out),
        .y_out        (y_out),
        .sel_out      (sel_out),
        .sum_in       (sum_in),
        .ovf_in       (ovf_in),
        .cout_in      (cout_in),
        .busy         (busy),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_cout  (result_cout),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    // Behavioural ripple adder: subtract is x + ~y + 1.
    logic [W-1:0] y_eff;
    logic [W:0]   full_sum;
    assign y_eff    = sel_out ? ~y_out : y_out;
    assign full_sum = {1'b0, x_out} + {1'b0, y_eff} + {{W{1'b0}}, sel_out};
    assign sum_in   = full_sum[W-1:0];
    assign cout_in  = full_sum[W];
    assign ovf_in   = (x_out[W-1] == y_eff[W-1]) && (sum_in[W-1] != x_out[W-1]);

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         sel;
        logic [W-1:0] sum;
        logic         ovf;
        logic         cout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [W-1:0] d, input logic s);
        din    = d;
        sel_in = s;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x_out"}, int'(x_out), 0);
        check({tag, "_y_out"}, int'(y_out), 0);
        check({tag, "_sel_out"}, int'(sel_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_ovf"}, int'(result_ovf), 0);
        check({tag, "_cout"}, int'(result_cout), 0);
        check({tag, "_valid"}, int'(result_valid), 0);
    endtask

    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input logic [W-1:0] e_sum, input logic e_ovf, input logic e_cout,
                           input bit do_ack, input string tag);
        int n;
        pulse_load(x, 1'b0);
        check({tag, "_busy_have_x"}, int'(busy), 0);
        check({tag, "_x_out"}, int'(x_out), int'(x));
        pulse_load(y, s);
        check({tag, "_busy_settle"}, int'(busy), 1);
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, SETTLE_CYCLES);
        check({tag, "_result"}, int'(result), int'(e_sum));
        check({tag, "_ovf"}, int'(result_ovf), int'(e_ovf));
        check({tag, "_cout"}, int'(result_cout), int'(e_cout));
        check({tag, "_x_hold"}, int'(x_out), int'(x));
        check({tag, "_y_hold"}, int'(y_out), int'(y));
        check({tag, "_sel_hold"}, int'(sel_out), int'(s));
        check({tag, "_busy_done"}, int'(busy), 1);
        $display("txn %s: x=%0d y=%0d sel=%0d -> result=%0d ovf=%0d cout=%0d latency=%0d",
                 tag, x, y, s, result, result_ovf, result_cout, n);
        if (do_ack) begin
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            check({tag, "_valid_after_ack"}, int'(result_valid), 0);
            check({tag, "_busy_after_ack"}, int'(busy), 0);
        end
    endtask

    initial begin
        vecs[0] = '{x: 6'd5,  y: 6'd3,  sel: 1'b0, sum: 6'd8,  ovf: 1'b0, cout: 1'b0};
        vecs[1] = '{x: 6'd31, y: 6'd1,  sel: 1'b0, sum: 6'd32, ovf: 1'b1, cout: 1'b0};
        vecs[2] = '{x: 6'd63, y: 6'd63, sel: 1'b0, sum: 6'd62, ovf: 1'b0, cout: 1'b1};
        vecs[3] = '{x: 6'd5,  y: 6'd7,  sel: 1'b1, sum: 6'd62, ovf: 1'b0, cout: 1'b0};
        vecs[4] = '{x: 6'd32, y: 6'd1,  sel: 1'b1, sum: 6'd31, ovf: 1'b1, cout: 1'b1};

        reset      = 1'b1;
        din        = '0;
        load       = 1'b0;
        sel_in     = 1'b0;
        result_ack = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].x, vecs[i].y, vecs[i].sel, vecs[i].sum, vecs[i].ovf,
                    vecs[i].cout, 1'b1, $sformatf("vec%0d", i));
        end

        // Hold: no ack for 10 cycles while load is strobed with din=9.
        run_txn(6'd5, 6'd3, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, "hold");
        din  = 6'd9;
        load = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("hold_result", int'(result), 8);
        check("hold_x_out", int'(x_out), 5);
        check("hold_y_out", int'(y_out), 3);
        check("hold_busy", int'(busy), 1);
        check("hold_valid", int'(result_valid), 1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        load       = 1'b0;
        check("ackload_valid", int'(result_valid), 0);
        check("ackload_busy", int'(busy), 0);
        check("ackload_x_out", int'(x_out), 5);
        check("ackload_result_kept", int'(result), 8);
        $display("txn hold: result=%0d x_out=%0d after ack+load", result, x_out);

        // Reset while the adder is settling.
        pulse_load(6'd10, 1'b0);
        pulse_load(6'd20, 1'b1);
        check("midsettle_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        tick();
        tick();
        check("midreset_still_idle", int'(busy), 0);
        $display("txn midreset: outputs cleared, busy=%0d", busy);
        run_txn(6'd2, 6'd2, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, "after_reset");

        // Back-to-back: loads immediately after the ack cycle.
        run_txn(6'd1, 6'd1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, "b2b");

        // Ack outside S_DONE must not disturb the sequence.
        result_ack = 1'b1;
        pulse_load(6'd4, 1'b0);
        result_ack = 1'b0;
        check("stray_ack_x_out", int'(x_out), 4);
        pulse_load(6'd6, 1'b1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("stray_ack_settle_busy", int'(busy), 1);
        tick();
        check("stray_ack_valid", int'(result_valid), 1);
        check("stray_ack_result", int'(result), 62);
        $display("txn stray_ack: 4-6 -> result=%0d valid=%0d", result, result_valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
